tlb_lookup_unit: RTL and testbench
==================================

// Module: tlb_lookup_unit
// PURPOSE
//  Responder side of the TLB search interface driven by the address-translation logic.
//  Holds TLBNUM entries and answers each search with a registered one-cycle response:
//  found, index, ppn, ps, plv, mat, d, v.
//  Also provides a TLBWR/TLBFILL write port, a TLBRD read port and a multi-cycle INVTLB walker.
//  Sits between the CSR/exception logic and the IF/MEM translation paths.
// PARAMETERS
//  TLBNUM   16  number of entries, power of two
//  IDXW     4   index width, equal to log2(TLBNUM)
// PORTS
//  clk          in   1    core clock
//  resetn       in   1    asynchronous, active-low reset
//  s_req        in   1    search request, sampled only when s_ready=1
//  s_ready      out  1    1 when the walker is idle
//  s_vppn       in   19   VA[31:13]
//  s_va_bit12   in   1    VA[12], selects the even/odd page for 4KB pages
//  s_asid       in   10   current ASID
//  s_rvalid     out  1    response valid, asserted the cycle after an accepted s_req
//  s_found      out  1    hit
//  s_index      out  IDXW hit entry index
//  s_ppn        out  20   selected page PPN
//  s_ps         out  6    page size: 12 or 21
//  s_plv/s_mat  out  2/2  selected page PLV and MAT
//  s_d/s_v      out  1/1  selected page dirty and valid bits
//  we           in   1    write strobe, accepted only when w_ready=1
//  w_ready      out  1    equal to s_ready
//  w_index      in   IDXW entry to write
//  w_vppn/w_asid  in 19/10  entry tag
//  w_ps         in   6    12 or 21; any other value is stored as 12
//  w_g/w_e      in   1/1  global bit and entry-exists bit
//  w_ppn0/w_ppn1  in 20/20  even/odd page PPN
//  w_plv0/w_mat0/w_d0/w_v0  in 2/2/1/1  even page attributes
//  w_plv1/w_mat1/w_d1/w_v1  in 2/2/1/1  odd page attributes
//  r_index      in   IDXW read index
//  r_*          out  -    all stored fields of entry r_index, registered, one-cycle latency
//  inv_req      in   1    start INVTLB, accepted only when s_ready=1
//  inv_op       in   5    INVTLB op code
//  inv_asid     in   10   ASID operand
//  inv_vppn     in   19   VA[31:13] operand
//  inv_done     out  1    one-cycle pulse when the walk finishes
// BEHAVIOUR
//  Reset: every e bit is 0, all outputs are 0, the walker is IDLE, s_ready=1.
//  Hit on entry i requires all of:
//   - e[i]=1
//   - g[i]=1, or asid[i]==s_asid
//   - VPPN compare: ps=12 compares vppn[18:0]; ps=21 compares vppn[18:9]
//  Multiple hits: the lowest index wins.
//  Odd-page select: s_va_bit12 when ps=12; s_vppn[8] when ps=21.
//  On a miss: s_found=0; index/ppn/ps/plv/mat/d/v are all 0.
//  Response registers: updated only on an accepted s_req and held otherwise;
//   s_rvalid is a 1-cycle pulse.
//  Write/search in the same cycle: the search sees the pre-write contents; the write
//   commits at the clock edge.
//  Write/read in the same cycle to the same index: r_* returns the old value.
//  Walker states: IDLE -> WALK (inv_req & s_ready) -> DONE -> IDLE.
//   - WALK visits index 0..TLBNUM-1, one entry per cycle, clearing e when the op matches.
//   - DONE pulses inv_done and returns to IDLE.
//   - Total: TLBNUM+1 cycles from acceptance to inv_done.
//  Op match rules:
//   - 0/1: all entries
//   - 2: g=1
//   - 3: g=0
//   - 4: g=0 & asid match
//   - 5: g=0 & asid match & VA match
//   - 6: (g=1 | asid match) & VA match
//   - VA match uses the entry's own ps width.
//   - ops 7-31: the walk still runs, nothing is cleared, inv_done still fires.
//  inv_op, inv_asid and inv_vppn are latched at acceptance; changes during the walk are ignored.
//  While not IDLE: s_ready=w_ready=0; s_req, we and inv_req are ignored and not queued.
//   The r_* read port keeps working.
//  inv_req and s_req in the same cycle: both are accepted; the search completes on
//   pre-walk contents.
//  Reset mid-walk: the walk aborts; all e bits return to 0.
// TESTING
//  1. Write idx3 {vppn=0x00010, asid=5, g=0, e=1, ps=12, ppn1=0xABCDE, v1=1};
//     search vppn=0x00010, bit12=1, asid=5
//     -> s_rvalid next cycle; found=1, index=3, ppn=0xABCDE, ps=12, v=1.
//  2. Same entry searched with asid=6 -> found=0 and all fields 0.
//     Rewrite it with g=1 -> found=1.
//  3. Idx1 and idx7 both match (ps=21, vppn[18:9] equal)
//     -> index=1; odd page selected by vppn[8].
//  4. INVTLB op=4, asid=5 over a mix of entries
//     -> only g=0 & asid=5 entries lose e; inv_done exactly 17 cycles after acceptance.
//  5. s_req, we and inv_req issued mid-walk
//     -> no s_rvalid, no write, no restart; s_ready returns the cycle after inv_done.
//  6. Assert resetn low during cycle 5 of a walk
//     -> all outputs 0; every subsequent search misses.

Source files
------------

// File: rtl/tlb_lookup_unit.sv
// tlb_lookup_unit
//   TLB responder for the address-translation logic.
//   - Holds TLBNUM entries. Each entry has one tag (vppn, asid, ps, g, e) and
//     an even/odd page pair (ppn, plv, mat, d, v).
//   - Search port: s_req / s_vppn / s_va_bit12 / s_asid in. The registered
//     response s_rvalid, s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d and
//     s_v appears one cycle later and is held until the next accepted search.
//   - Write port (TLBWR/TLBFILL): we, w_index and the w_* fields. w_ready
//     mirrors s_ready.
//   - Read port (TLBRD): r_index in, all stored fields out on r_*, registered
//     with one-cycle latency. It keeps working while a walk is in progress.
//   - INVTLB walker: inv_req, inv_op, inv_asid and inv_vppn in; inv_done out.
//     The walker visits one entry per cycle. inv_done pulses TLBNUM+1 cycles
//     after acceptance.
//   - clk is the core clock. resetn is an asynchronous, active-low reset.
module tlb_lookup_unit #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = 4
) (
    input  logic            clk,
    input  logic            resetn,
    // search
    input  logic            s_req,
    output logic            s_ready,
    input  logic [18:0]     s_vppn,
    input  logic            s_va_bit12,
    input  logic [9:0]      s_asid,
    output logic            s_rvalid,
    output logic            s_found,
    output logic [IDXW-1:0] s_index,
    output logic [19:0]     s_ppn,
    output logic [5:0]      s_ps,
    output logic [1:0]      s_plv,
    output logic [1:0]      s_mat,
    output logic            s_d,
    output logic            s_v,
    // write
    input  logic            we,
    output logic            w_ready,
    input  logic [IDXW-1:0] w_index,
    input  logic [18:0]     w_vppn,
    input  logic [9:0]      w_asid,
    input  logic [5:0]      w_ps,
    input  logic            w_g,
    input  logic            w_e,
    input  logic [19:0]     w_ppn0,
    input  logic [1:0]      w_plv0,
    input  logic [1:0]      w_mat0,
    input  logic            w_d0,
    input  logic            w_v0,
    input  logic [19:0]     w_ppn1,
    input  logic [1:0]      w_plv1,
    input  logic [1:0]      w_mat1,
    input  logic            w_d1,
    input  logic            w_v1,
    // read
    input  logic [IDXW-1:0] r_index,
    output logic [18:0]     r_vppn,
    output logic [9:0]      r_asid,
    output logic [5:0]      r_ps,
    output logic            r_g,
    output logic            r_e,
    output logic [19:0]     r_ppn0,
    output logic [1:0]      r_plv0,
    output logic [1:0]      r_mat0,
    output logic            r_d0,
    output logic            r_v0,
    output logic [19:0]     r_ppn1,
    output logic [1:0]      r_plv1,
    output logic [1:0]      r_mat1,
    output logic            r_d1,
    output logic            r_v1,
    // invalidate
    input  logic            inv_req,
    input  logic [4:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [18:0]     inv_vppn,
    output logic            inv_done
);

    typedef struct packed {
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic [5:0]  ps;
        logic        g;
        logic        e;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_DONE} state_t;

    entry_t          ent_q [TLBNUM];
    entry_t          ent_d [TLBNUM];
    entry_t          r_q, r_d;
    state_t          state_q, state_d;
    logic [IDXW-1:0] walk_idx_q, walk_idx_d;
    logic [4:0]      op_q, op_d;
    logic [9:0]      op_asid_q, op_asid_d;
    logic [18:0]     op_vppn_q, op_vppn_d;

    logic            s_rvalid_q, s_rvalid_d;
    logic            s_found_q, s_found_d;
    logic [IDXW-1:0] s_index_q, s_index_d;
    logic [19:0]     s_ppn_q, s_ppn_d;
    logic [5:0]      s_ps_q, s_ps_d;
    logic [1:0]      s_plv_q, s_plv_d;
    logic [1:0]      s_mat_q, s_mat_d;
    logic            s_d_q, s_d_d;
    logic            s_v_q, s_v_d;

    logic            idle, s_acc, w_acc;
    logic [TLBNUM-1:0] hit, inv_hit;
    logic            hit_found, hit_odd;
    logic [IDXW-1:0] hit_idx;

    assign idle     = (state_q == ST_IDLE);
    assign s_ready  = idle;
    assign w_ready  = idle;
    assign inv_done = (state_q == ST_DONE);
    assign s_acc    = s_req & idle;
    assign w_acc    = we & idle;

    // Per-entry match logic for the search port and the invalidate walker.
    // The compare width follows each entry's own page size.
    for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_ent
        logic big, va_s, va_i, asid_i, op_sel;
        assign big    = (ent_q[gi].ps == 6'd21);
        assign va_s   = big ? (ent_q[gi].vppn[18:9] == s_vppn[18:9])
                            : (ent_q[gi].vppn == s_vppn);
        assign va_i   = big ? (ent_q[gi].vppn[18:9] == op_vppn_q[18:9])
                            : (ent_q[gi].vppn == op_vppn_q);
        assign asid_i = (ent_q[gi].asid == op_asid_q);
        always_comb begin
            op_sel = 1'b0;
            case (op_q)
                5'd0, 5'd1: op_sel = 1'b1;
                5'd2:       op_sel = ent_q[gi].g;
                5'd3:       op_sel = ~ent_q[gi].g;
                5'd4:       op_sel = ~ent_q[gi].g & asid_i;
                5'd5:       op_sel = ~ent_q[gi].g & asid_i & va_i;
                5'd6:       op_sel = (ent_q[gi].g | asid_i) & va_i;
                default:    op_sel = 1'b0;
            endcase
        end
        assign hit[gi] = ent_q[gi].e & (ent_q[gi].g | (ent_q[gi].asid == s_asid)) & va_s;
        assign inv_hit[gi] = op_sel;
    end

    // Lowest index wins. The scan runs downward so the last assignment
    // comes from the lowest hitting entry.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_found = 1'b1;
                hit_idx   = IDXW'(i);
            end
        end
    end

    assign hit_odd = (ent_q[hit_idx].ps == 6'd21) ? s_vppn[8] : s_va_bit12;

    // Search response: loaded only on an accepted request, otherwise held.
    always_comb begin
        s_rvalid_d = s_acc;
        s_found_d  = s_found_q;
        s_index_d  = s_index_q;
        s_ppn_d    = s_ppn_q;
        s_ps_d     = s_ps_q;
        s_plv_d    = s_plv_q;
        s_mat_d    = s_mat_q;
        s_d_d      = s_d_q;
        s_v_d      = s_v_q;
        if (s_acc) begin
            s_found_d = hit_found;
            s_index_d = '0;
            s_ppn_d   = '0;
            s_ps_d    = '0;
            s_plv_d   = '0;
            s_mat_d   = '0;
            s_d_d     = 1'b0;
            s_v_d     = 1'b0;
            if (hit_found) begin
                s_index_d = hit_idx;
                s_ps_d    = ent_q[hit_idx].ps;
                s_ppn_d   = hit_odd ? ent_q[hit_idx].ppn1 : ent_q[hit_idx].ppn0;
                s_plv_d   = hit_odd ? ent_q[hit_idx].plv1 : ent_q[hit_idx].plv0;
                s_mat_d   = hit_odd ? ent_q[hit_idx].mat1 : ent_q[hit_idx].mat0;
                s_d_d     = hit_odd ? ent_q[hit_idx].d1   : ent_q[hit_idx].d0;
                s_v_d     = hit_odd ? ent_q[hit_idx].v1   : ent_q[hit_idx].v0;
            end
        end
    end

    // Entry update. A write is only possible while idle and a clear only
    // while walking, so the two never touch the same cycle.
    always_comb begin
        ent_d = ent_q;
        if (w_acc) begin
            ent_d[w_index].vppn = w_vppn;
            ent_d[w_index].asid = w_asid;
            ent_d[w_index].ps   = (w_ps == 6'd21) ? 6'd21 : 6'd12;
            ent_d[w_index].g    = w_g;
            ent_d[w_index].e    = w_e;
            ent_d[w_index].ppn0 = w_ppn0;
            ent_d[w_index].plv0 = w_plv0;
            ent_d[w_index].mat0 = w_mat0;
            ent_d[w_index].d0   = w_d0;
            ent_d[w_index].v0   = w_v0;
            ent_d[w_index].ppn1 = w_ppn1;
            ent_d[w_index].plv1 = w_plv1;
            ent_d[w_index].mat1 = w_mat1;
            ent_d[w_index].d1   = w_d1;
            ent_d[w_index].v1   = w_v1;
        end
        if ((state_q == ST_WALK) && inv_hit[walk_idx_q]) begin
            ent_d[walk_idx_q].e = 1'b0;
        end
    end

    // The read port samples the pre-write contents.
    assign r_d = ent_q[r_index];

    // Walker next state. The operands are latched at acceptance.
    always_comb begin
        state_d    = state_q;
        walk_idx_d = walk_idx_q;
        op_d       = op_q;
        op_asid_d  = op_asid_q;
        op_vppn_d  = op_vppn_q;
        case (state_q)
            ST_IDLE: begin
                if (inv_req) begin
                    state_d    = ST_WALK;
                    walk_idx_d = '0;
                    op_d       = inv_op;
                    op_asid_d  = inv_asid;
                    op_vppn_d  = inv_vppn;
                end
            end
            ST_WALK: begin
                walk_idx_d = walk_idx_q + 1'b1;
                if (walk_idx_q == IDXW'(TLBNUM - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                ent_q[i] <= '0;
            end
            r_q        <= '0;
            state_q    <= ST_IDLE;
            walk_idx_q <= '0;
            op_q       <= '0;
            op_asid_q  <= '0;
            op_vppn_q  <= '0;
            s_rvalid_q <= 1'b0;
            s_found_q  <= 1'b0;
            s_index_q  <= '0;
            s_ppn_q    <= '0;
            s_ps_q     <= '0;
            s_plv_q    <= '0;
            s_mat_q    <= '0;
            s_d_q      <= 1'b0;
            s_v_q      <= 1'b0;
        end else begin
            ent_q      <= ent_d;
            r_q        <= r_d;
            state_q    <= state_d;
            walk_idx_q <= walk_idx_d;
            op_q       <= op_d;
            op_asid_q  <= op_asid_d;
            op_vppn_q  <= op_vppn_d;
            s_rvalid_q <= s_rvalid_d;
            s_found_q  <= s_found_d;
            s_index_q  <= s_index_d;
            s_ppn_q    <= s_ppn_d;
            s_ps_q     <= s_ps_d;
            s_plv_q    <= s_plv_d;
            s_mat_q    <= s_mat_d;
            s_d_q      <= s_d_d;
            s_v_q      <= s_v_d;
        end
    end

    assign s_rvalid = s_rvalid_q;
    assign s_found  = s_found_q;
    assign s_index  = s_index_q;
    assign s_ppn    = s_ppn_q;
    assign s_ps     = s_ps_q;
    assign s_plv    = s_plv_q;
    assign s_mat    = s_mat_q;
    assign s_d      = s_d_q;
    assign s_v      = s_v_q;

    assign r_vppn = r_q.vppn;
    assign r_asid = r_q.asid;
    assign r_ps   = r_q.ps;
    assign r_g    = r_q.g;
    assign r_e    = r_q.e;
    assign r_ppn0 = r_q.ppn0;
    assign r_plv0 = r_q.plv0;
    assign r_mat0 = r_q.mat0;
    assign r_d0   = r_q.d0;
    assign r_v0   = r_q.v0;
    assign r_ppn1 = r_q.ppn1;
    assign r_plv1 = r_q.plv1;
    assign r_mat1 = r_q.mat1;
    assign r_d1   = r_q.d1;
    assign r_v1   = r_q.v1;

endmodule

// File: tb/tb_tlb_lookup_unit.sv
// tb_tlb_lookup_unit
//   Self-checking bench for tlb_lookup_unit. A behavioural model (arrays of
//   entry fields plus a walk cycle counter) predicts every output on every
//   cycle. Directed scenarios also pin literal values. A randomized phase
//   follows the directed scenarios.
module tb_tlb_lookup_unit;
    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic s_req, s_va_bit12;
    logic [18:0] s_vppn;
    logic [9:0] s_asid;
    logic we, w_g, w_e, w_d0, w_v0, w_d1, w_v1;
    logic [IDXW-1:0] w_index, r_index;
    logic [18:0] w_vppn;
    logic [9:0] w_asid;
    logic [5:0] w_ps;
    logic [19:0] w_ppn0, w_ppn1;
    logic [1:0] w_plv0, w_mat0, w_plv1, w_mat1;
    logic inv_req;
    logic [4:0] inv_op;
    logic [9:0] inv_asid;
    logic [18:0] inv_vppn;

    logic s_ready, s_rvalid, s_found, s_d, s_v, w_ready, inv_done;
    logic [IDXW-1:0] s_index;
    logic [19:0] s_ppn;
    logic [5:0] s_ps;
    logic [1:0] s_plv, s_mat;
    logic [18:0] r_vppn;
    logic [9:0] r_asid;
    logic [5:0] r_ps;
    logic r_g, r_e, r_d0, r_v0, r_d1, r_v1;
    logic [19:0] r_ppn0, r_ppn1;
    logic [1:0] r_plv0, r_mat0, r_plv1, r_mat1;

    tlb_lookup_unit #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
        .clk(clk), .resetn(resetn),
        .s_req(s_req), .s_ready(s_ready), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12),
        .s_asid(s_asid), .s_rvalid(s_rvalid), .s_found(s_found), .s_index(s_index),
        .s_ppn(s_ppn), .s_ps(s_ps), .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
        .we(we), .w_ready(w_ready), .w_index(w_index), .w_vppn(w_vppn), .w_asid(w_asid),
        .w_ps(w_ps), .w_g(w_g), .w_e(w_e), .w_ppn0(w_ppn0), .w_plv0(w_plv0),
        .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0), .w_ppn1(w_ppn1), .w_plv1(w_plv1),
        .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vppn(r_vppn), .r_asid(r_asid), .r_ps(r_ps), .r_g(r_g),
        .r_e(r_e), .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0),
        .r_v0(r_v0), .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1),
        .r_v1(r_v1),
        .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .inv_done(inv_done)
    );

    // ---------------- behavioural model ----------------
    logic [18:0] m_vppn [TLBNUM];
    logic [9:0]  m_asid [TLBNUM];
    logic [5:0]  m_ps   [TLBNUM];
    logic        m_g [TLBNUM], m_e [TLBNUM], m_known [TLBNUM];
    logic [19:0] m_ppn [TLBNUM][2];
    logic [1:0]  m_plv [TLBNUM][2];
    logic [1:0]  m_mat [TLBNUM][2];
    logic        m_d [TLBNUM][2], m_v [TLBNUM][2];

    // walk_cyc: -1 when idle, else cycles since acceptance (17 = done pulse)
    int          walk_cyc;
    logic [4:0]  l_op;
    logic [9:0]  l_asid;
    logic [18:0] l_vppn;

    logic x_rvalid, x_found, x_d, x_v;
    logic [IDXW-1:0] x_index;
    logic [19:0] x_ppn;
    logic [5:0] x_ps;
    logic [1:0] x_plv, x_mat;
    logic x_r_e, x_r_known, x_r_g;
    logic [18:0] x_r_vppn;
    logic [9:0] x_r_asid;
    logic [5:0] x_r_ps;
    logic [19:0] x_r_ppn [2];
    logic [1:0] x_r_plv [2], x_r_mat [2];
    logic x_r_d [2], x_r_v [2];

    int n_cmp = 0;
    int n_bad = 0;
    logic [18:0] vpool [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit va_eq(input int i, input logic [18:0] va);
        if (m_ps[i] == 6'd21) return (m_vppn[i] >> 9) == (va >> 9);
        return m_vppn[i] == va;
    endfunction

    function automatic bit op_hit(input int i);
        bit am, vm;
        am = (m_asid[i] == l_asid);
        vm = va_eq(i, l_vppn);
        case (l_op)
            5'd0, 5'd1: return 1'b1;
            5'd2: return m_g[i];
            5'd3: return !m_g[i];
            5'd4: return !m_g[i] && am;
            5'd5: return !m_g[i] && am && vm;
            5'd6: return (m_g[i] || am) && vm;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TLBNUM; i++) begin
            m_e[i] = 1'b0;
            m_known[i] = 1'b0;
        end
        walk_cyc = -1;
        x_rvalid = 0; x_found = 0; x_index = 0; x_ppn = 0; x_ps = 0;
        x_plv = 0; x_mat = 0; x_d = 0; x_v = 0;
    endtask

    task automatic model_search();
        int p;
        x_found = 0; x_index = 0; x_ppn = 0; x_ps = 0; x_plv = 0; x_mat = 0; x_d = 0; x_v = 0;
        for (int i = 0; i < TLBNUM; i++) begin
            if (!x_found && m_e[i] && (m_g[i] || m_asid[i] == s_asid) && va_eq(i, s_vppn)) begin
                x_found = 1;
                x_index = IDXW'(i);
                x_ps = m_ps[i];
                p = (m_ps[i] == 6'd21) ? int'(s_vppn[8]) : int'(s_va_bit12);
                x_ppn = m_ppn[i][p]; x_plv = m_plv[i][p]; x_mat = m_mat[i][p];
                x_d = m_d[i][p]; x_v = m_v[i][p];
            end
        end
    endtask

    task automatic model_write();
        int wi;
        wi = int'(w_index);
        m_vppn[wi] = w_vppn; m_asid[wi] = w_asid; m_g[wi] = w_g; m_e[wi] = w_e;
        m_ps[wi] = (w_ps == 6'd21) ? 6'd21 : 6'd12;
        m_ppn[wi][0] = w_ppn0; m_plv[wi][0] = w_plv0; m_mat[wi][0] = w_mat0;
        m_d[wi][0] = w_d0; m_v[wi][0] = w_v0;
        m_ppn[wi][1] = w_ppn1; m_plv[wi][1] = w_plv1; m_mat[wi][1] = w_mat1;
        m_d[wi][1] = w_d1; m_v[wi][1] = w_v1;
        m_known[wi] = 1'b1;
    endtask

    task automatic check_outputs();
        chk("s_ready", 32'(s_ready), 32'(walk_cyc < 0));
        chk("w_ready", 32'(w_ready), 32'(walk_cyc < 0));
        chk("inv_done", 32'(inv_done), 32'(walk_cyc == TLBNUM + 1));
        chk("s_rvalid", 32'(s_rvalid), 32'(x_rvalid));
        chk("s_found", 32'(s_found), 32'(x_found));
        chk("s_index", 32'(s_index), 32'(x_index));
        chk("s_ppn", 32'(s_ppn), 32'(x_ppn));
        chk("s_ps", 32'(s_ps), 32'(x_ps));
        chk("s_plv", 32'(s_plv), 32'(x_plv));
        chk("s_mat", 32'(s_mat), 32'(x_mat));
        chk("s_d", 32'(s_d), 32'(x_d));
        chk("s_v", 32'(s_v), 32'(x_v));
        chk("r_e", 32'(r_e), 32'(x_r_e));
        if (x_r_known) begin
            chk("r_vppn", 32'(r_vppn), 32'(x_r_vppn));
            chk("r_asid", 32'(r_asid), 32'(x_r_asid));
            chk("r_ps", 32'(r_ps), 32'(x_r_ps));
            chk("r_g", 32'(r_g), 32'(x_r_g));
            chk("r_ppn0", 32'(r_ppn0), 32'(x_r_ppn[0]));
            chk("r_plv0", 32'(r_plv0), 32'(x_r_plv[0]));
            chk("r_mat0", 32'(r_mat0), 32'(x_r_mat[0]));
            chk("r_d0", 32'(r_d0), 32'(x_r_d[0]));
            chk("r_v0", 32'(r_v0), 32'(x_r_v[0]));
            chk("r_ppn1", 32'(r_ppn1), 32'(x_r_ppn[1]));
            chk("r_plv1", 32'(r_plv1), 32'(x_r_plv[1]));
            chk("r_mat1", 32'(r_mat1), 32'(x_r_mat[1]));
            chk("r_d1", 32'(r_d1), 32'(x_r_d[1]));
            chk("r_v1", 32'(r_v1), 32'(x_r_v[1]));
        end
    endtask

    // One clock cycle: predict from current inputs and model, advance, compare.
    task automatic cycle();
        bit rdy;
        int ri;
        rdy = (walk_cyc < 0);
        ri = int'(r_index);
        x_r_e = m_e[ri]; x_r_known = m_known[ri]; x_r_vppn = m_vppn[ri];
        x_r_asid = m_asid[ri]; x_r_ps = m_ps[ri]; x_r_g = m_g[ri];
        for (int p = 0; p < 2; p++) begin
            x_r_ppn[p] = m_ppn[ri][p]; x_r_plv[p] = m_plv[ri][p]; x_r_mat[p] = m_mat[ri][p];
            x_r_d[p] = m_d[ri][p]; x_r_v[p] = m_v[ri][p];
        end
        x_rvalid = 1'b0;
        if (rdy && s_req) begin
            x_rvalid = 1'b1;
            model_search();
        end
        if (walk_cyc >= 1 && walk_cyc <= TLBNUM) begin
            if (op_hit(walk_cyc - 1)) m_e[walk_cyc - 1] = 1'b0;
        end
        if (rdy && we) model_write();
        if (rdy && inv_req) begin
            l_op = inv_op; l_asid = inv_asid; l_vppn = inv_vppn;
            walk_cyc = 1;
        end else if (walk_cyc >= 1 && walk_cyc <= TLBNUM) begin
            walk_cyc++;
        end else begin
            walk_cyc = -1;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_w_ready"}, 32'(w_ready), 32'd1);
        chk({tag, "_inv_done"}, 32'(inv_done), 32'd0);
        chk({tag, "_s_resp"}, {s_rvalid, s_found, s_index, s_ps, s_d, s_v, s_plv, s_mat}, 32'd0);
        chk({tag, "_s_ppn"}, 32'(s_ppn), 32'd0);
        chk({tag, "_r_tag"}, {r_vppn, r_asid, r_g, r_e, 1'b0}, 32'd0);
        chk({tag, "_r_ps"}, 32'(r_ps), 32'd0);
        chk({tag, "_r_page"}, {r_ppn0, r_plv0, r_mat0, r_d0, r_v0, 6'd0}, 32'd0);
        chk({tag, "_r_page1"}, {r_ppn1, r_plv1, r_mat1, r_d1, r_v1, 6'd0}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        check_reset_outputs(tag);
        resetn = 1'b1;
    endtask

    task automatic idle_inputs();
        s_req = 0; we = 0; inv_req = 0;
    endtask

    task automatic put_write(input int idx, input logic [18:0] vppn, input logic [9:0] asid,
                             input logic g, input logic [5:0] ps, input logic [19:0] ppn0,
                             input logic [19:0] ppn1, input logic v1);
        we = 1; w_index = IDXW'(idx); w_vppn = vppn; w_asid = asid; w_g = g; w_e = 1;
        w_ps = ps; w_ppn0 = ppn0; w_ppn1 = ppn1;
        w_plv0 = 2'd0; w_mat0 = 2'd0; w_d0 = 0; w_v0 = 1;
        w_plv1 = 2'd3; w_mat1 = 2'd1; w_d1 = 1; w_v1 = v1;
        cycle();
        we = 0;
    endtask

    task automatic do_search(input logic [18:0] vppn, input logic bit12, input logic [9:0] asid);
        s_req = 1; s_vppn = vppn; s_va_bit12 = bit12; s_asid = asid;
        cycle();
        s_req = 0;
    endtask

    task automatic read_e(input int idx, input logic expv, input string name);
        r_index = IDXW'(idx);
        cycle();
        chk(name, 32'(r_e), 32'(expv));
    endtask

    task automatic rand_fields();
        w_index = IDXW'($urandom_range(0, TLBNUM - 1));
        w_vppn = vpool[$urandom_range(0, 3)];
        if ($urandom_range(0, 3) == 0) w_vppn = w_vppn ^ 19'($urandom_range(0, 511));
        w_asid = 10'($urandom_range(5, 7));
        case ($urandom_range(0, 2))
            0: w_ps = 6'd12;
            1: w_ps = 6'd21;
            default: w_ps = 6'($urandom);
        endcase
        w_g = ($urandom_range(0, 3) == 0); w_e = ($urandom_range(0, 7) != 0);
        w_ppn0 = 20'($urandom); w_ppn1 = 20'($urandom);
        w_plv0 = 2'($urandom); w_mat0 = 2'($urandom); w_d0 = 1'($urandom); w_v0 = 1'($urandom);
        w_plv1 = 2'($urandom); w_mat1 = 2'($urandom); w_d1 = 1'($urandom); w_v1 = 1'($urandom);
    endtask

    int n;

    initial begin
        vpool[0] = 19'h00010; vpool[1] = 19'h12345; vpool[2] = 19'h12200; vpool[3] = 19'h7FE00;
        resetn = 1'b0;
        idle_inputs();
        s_vppn = 0; s_va_bit12 = 0; s_asid = 0; r_index = 0;
        inv_op = 0; inv_asid = 0; inv_vppn = 0;
        rand_fields();
        for (int i = 0; i < TLBNUM; i++) begin
            m_vppn[i] = 0; m_asid[i] = 0; m_ps[i] = 0; m_g[i] = 0;
            for (int p = 0; p < 2; p++) begin
                m_ppn[i][p] = 0; m_plv[i][p] = 0; m_mat[i][p] = 0; m_d[i][p] = 0; m_v[i][p] = 0;
            end
        end
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("reset");
        resetn = 1'b1;

        // 1: basic 4KB hit on the odd page
        put_write(3, 19'h00010, 10'd5, 1'b0, 6'd12, 20'h0, 20'hABCDE, 1'b1);
        do_search(19'h00010, 1'b1, 10'd5);
        chk("t1_rvalid", 32'(s_rvalid), 32'd1);
        chk("t1_found", 32'(s_found), 32'd1);
        chk("t1_index", 32'(s_index), 32'd3);
        chk("t1_ppn", 32'(s_ppn), 32'hABCDE);
        chk("t1_ps", 32'(s_ps), 32'd12);
        chk("t1_v", 32'(s_v), 32'd1);
        cycle();
        chk("t1_rvalid_pulse", 32'(s_rvalid), 32'd0);
        chk("t1_hold_ppn", 32'(s_ppn), 32'hABCDE);

        // 2: ASID mismatch, then global entry
        do_search(19'h00010, 1'b1, 10'd6);
        chk("t2_miss_found", 32'(s_found), 32'd0);
        chk("t2_miss_fields", {s_index, s_ps, s_plv, s_mat, s_d, s_v}, 32'd0);
        chk("t2_miss_ppn", 32'(s_ppn), 32'd0);
        put_write(3, 19'h00010, 10'd5, 1'b1, 6'd12, 20'h0, 20'hABCDE, 1'b1);
        do_search(19'h00010, 1'b1, 10'd6);
        chk("t2_g_found", 32'(s_found), 32'd1);
        chk("t2_g_index", 32'(s_index), 32'd3);

        // 3: two 2MB entries match, lowest index wins, vppn[8] selects page
        put_write(7, 19'h12200, 10'd6, 1'b1, 6'd21, 20'h77770, 20'h77771, 1'b1);
        put_write(1, 19'h12345, 10'd5, 1'b1, 6'd21, 20'h11111, 20'h22222, 1'b1);
        do_search(19'h12300, 1'b0, 10'd7);
        chk("t3_index", 32'(s_index), 32'd1);
        chk("t3_ppn_odd", 32'(s_ppn), 32'h22222);
        chk("t3_ps", 32'(s_ps), 32'd21);
        do_search(19'h12200, 1'b1, 10'd7);
        chk("t3_ppn_even", 32'(s_ppn), 32'h11111);

        // 4: INVTLB op 4, asid 5
        put_write(2, 19'h00040, 10'd5, 1'b0, 6'd12, 20'h1, 20'h2, 1'b1);
        put_write(4, 19'h00040, 10'd6, 1'b0, 6'd12, 20'h1, 20'h2, 1'b1);
        put_write(5, 19'h00050, 10'd5, 1'b0, 6'd12, 20'h1, 20'h2, 1'b1);
        inv_req = 1; inv_op = 5'd4; inv_asid = 10'd5; inv_vppn = 19'h0;
        cycle();
        inv_req = 0; inv_op = 5'd0; inv_asid = 10'd9;
        n = 1;
        while (!inv_done && n < 40) begin
            cycle();
            n++;
        end
        chk("t4_done_latency", 32'(n), 32'd17);
        chk("t4_busy_at_done", 32'(s_ready), 32'd0);
        cycle();
        chk("t4_ready_after", 32'(s_ready), 32'd1);
        read_e(1, 1'b1, "t4_e1");
        read_e(2, 1'b0, "t4_e2");
        read_e(3, 1'b1, "t4_e3");
        read_e(4, 1'b1, "t4_e4");
        read_e(5, 1'b0, "t4_e5");
        read_e(7, 1'b1, "t4_e7");

        // 5: requests during a walk are dropped
        inv_req = 1; inv_op = 5'd9;
        cycle();
        inv_req = 0;
        n = 1;
        for (int k = 0; k < 2; k++) begin cycle(); n++; end
        s_req = 1; s_vppn = 19'h00010; s_va_bit12 = 1; s_asid = 10'd5;
        we = 1; w_index = 4'd9; w_e = 1; inv_req = 1;
        for (int k = 0; k < 3; k++) begin
            cycle(); n++;
            chk("t5_no_rvalid", 32'(s_rvalid), 32'd0);
        end
        idle_inputs();
        while (!inv_done && n < 40) begin
            cycle();
            n++;
        end
        chk("t5_done_latency", 32'(n), 32'd17);
        cycle();
        chk("t5_ready_back", 32'(s_ready), 32'd1);
        cycle();
        chk("t5_no_restart", 32'({s_ready, inv_done}), 32'b10);
        read_e(9, 1'b0, "t5_no_write");
        read_e(1, 1'b1, "t5_nothing_cleared");

        // 6: reset in the middle of an op 0 walk
        inv_req = 1; inv_op = 5'd0;
        cycle();
        inv_req = 0;
        for (int k = 0; k < 4; k++) cycle();
        do_reset("t6_reset");
        do_search(19'h00010, 1'b1, 10'd5);
        chk("t6_miss_after_reset", 32'(s_found), 32'd0);
        read_e(3, 1'b0, "t6_e3_cleared");

        // randomized phase
        for (int k = 0; k < 2500; k++) begin
            s_req = ($urandom_range(0, 1) == 1);
            s_vppn = vpool[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) s_vppn = s_vppn ^ 19'($urandom_range(0, 511));
            s_va_bit12 = 1'($urandom);
            s_asid = 10'($urandom_range(5, 7));
            we = ($urandom_range(0, 9) < 3);
            rand_fields();
            r_index = IDXW'($urandom_range(0, TLBNUM - 1));
            inv_req = ($urandom_range(0, 39) == 0);
            inv_op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            inv_asid = 10'($urandom_range(5, 7));
            inv_vppn = vpool[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 0) inv_vppn = inv_vppn ^ 19'($urandom_range(0, 511));
            cycle();
            if (k == 1200) do_reset("rand_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
